// File: rtl/mem_read_stage_pkg.sv
// rtl/mem_read_stage_pkg.sv - shared field positions, size codes and FSM encoding for the memory read stage
package mem_read_stage_pkg;

  // i_reg2 field positions
  localparam int IMM_LSB      = 0;
  localparam int IMM_MSB      = 47;
  localparam int OP_LSB       = 48;
  localparam int OP_MSB       = 49;
  localparam int IMMSZ_LSB    = 50;
  localparam int IMMSZ_MSB    = 51;
  localparam int ISMEMWB_BIT  = 52;
  localparam int ISMEMRD_BIT  = 53;
  localparam int SR1_LSB      = 54;
  localparam int SR1_MSB      = 56;
  localparam int FARJMP_BIT   = 57;
  localparam int ZERO_LSB     = 58;

  // op codes and the byte counts they select
  localparam logic [1:0] OP_BYTE     = 2'b00;
  localparam logic [1:0] OP_HALF     = 2'b01;
  localparam logic [1:0] OP_WORD     = 2'b10;
  localparam logic [1:0] OP_WORD_ALT = 2'b11;

  localparam logic [2:0] SIZE_BYTE = 3'd1;
  localparam logic [2:0] SIZE_HALF = 3'd2;
  localparam logic [2:0] SIZE_WORD = 3'd4;

  // distance between consecutive data-cache words
  localparam logic [31:0] WORD_STRIDE = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD1  = 2'b01,
    ST_RD2  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // operand size in bytes for an op code
  function automatic logic [2:0] op_size(input logic [1:0] op);
    logic [2:0] sz;
    case (op)
      OP_BYTE:     sz = SIZE_BYTE;
      OP_HALF:     sz = SIZE_HALF;
      OP_WORD:     sz = SIZE_WORD;
      OP_WORD_ALT: sz = SIZE_WORD;
      default:     sz = SIZE_WORD;
    endcase
    return sz;
  endfunction

  // true when the operand crosses into the next word
  function automatic logic is_split(input logic [1:0] off, input logic [1:0] op);
    return ({1'b0, off} + op_size(op)) > SIZE_WORD;
  endfunction

endpackage

// File: rtl/mem_read_stage_align.sv
// rtl/mem_read_stage_align.sv - byte merge, shift and zero-extend of the fetched word pair
module mrd_align
  import mem_read_stage_pkg::*;
(
  input  logic [31:0] word_lo_i,
  input  logic [31:0] word_hi_i,
  input  logic [1:0]  byte_off_i,
  input  logic [1:0]  op_i,
  output logic [31:0] data_o
);

  logic [31:0] window;
  logic [2:0]  size;
  logic        unused_hi;

  // The highest offset is 3, so the top byte of the second word never lands in the result.
  assign unused_hi = ^word_hi_i[31:24];

  // Select the 32-bit window starting at the byte offset, then mask to the operand size.
  always_comb begin
    window = word_lo_i;
    case (byte_off_i)
      2'd0:    window = word_lo_i;
      2'd1:    window = {word_hi_i[7:0],  word_lo_i[31:8]};
      2'd2:    window = {word_hi_i[15:0], word_lo_i[31:16]};
      2'd3:    window = {word_hi_i[23:0], word_lo_i[31:24]};
      default: window = word_lo_i;
    endcase

    size   = op_size(op_i);
    data_o = window;
    case (size)
      SIZE_BYTE: data_o = {24'd0, window[7:0]};
      SIZE_HALF: data_o = {16'd0, window[15:0]};
      default:   data_o = window;
    endcase
  end

endmodule

// File: rtl/mem_read_stage.sv
// rtl/mem_read_stage.sv - memory operand fetch stage between address generation and execute
module mem_read_stage
  import mem_read_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  input  logic [63:0] i_reg1,
  input  logic [63:0] i_reg2,
  input  logic [31:0] i_reg3,
  output logic        o_stall,
  output logic        dc_req,
  output logic [31:0] dc_addr,
  input  logic        dc_ack,
  input  logic [31:0] dc_rdata,
  input  logic        i_ex_ready,
  output logic        o_valid,
  output logic [31:0] o_src1,
  output logic [31:0] o_src2,
  output logic [31:0] o_mem_data,
  output logic [31:0] o_addr,
  output logic [47:0] o_imm,
  output logic [1:0]  o_op,
  output logic [1:0]  o_immSize,
  output logic        o_isMemWb,
  output logic [2:0]  o_sr1,
  output logic        o_far_jmp
);

  state_e      state_q, state_d;
  logic        dc_req_q, dc_req_d;
  logic [31:0] dc_addr_q, dc_addr_d;
  logic [31:0] word1_q, word1_d;
  logic [31:0] word2_q, word2_d;
  logic        valid_q, valid_d;
  logic [31:0] src1_q, src1_d;
  logic [31:0] src2_q, src2_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic [31:0] addr_q, addr_d;
  logic [47:0] imm_q, imm_d;
  logic [1:0]  op_q, op_d;
  logic [1:0]  imm_size_q, imm_size_d;
  logic        is_mem_wb_q, is_mem_wb_d;
  logic [2:0]  sr1_q, sr1_d;
  logic        far_jmp_q, far_jmp_d;

  logic        accept;
  logic        ack;
  logic [31:0] aligned_data;
  logic        unused_reg2;

  // Upper bits of i_reg2 are defined as zero and carry no information.
  assign unused_reg2 = ^i_reg2[63:ZERO_LSB];

  // Hold upstream while a read is in flight or the execute stage refuses the current bundle.
  assign o_stall = (state_q != ST_IDLE) || (valid_q && !i_ex_ready);
  assign accept  = i_valid && !o_stall;
  // An acknowledge only counts against a live request.
  assign ack     = dc_ack && dc_req_q;

  mrd_align u_align (
    .word_lo_i  (word1_q),
    .word_hi_i  (word2_q),
    .byte_off_i (addr_q[1:0]),
    .op_i       (op_q),
    .data_o     (aligned_data)
  );

  // Next-state logic: acceptance, request sequencing and output bundle update.
  always_comb begin
    state_d     = state_q;
    dc_req_d    = dc_req_q;
    dc_addr_d   = dc_addr_q;
    word1_d     = word1_q;
    word2_d     = word2_q;
    valid_d     = valid_q && !i_ex_ready;
    src1_d      = src1_q;
    src2_d      = src2_q;
    mem_data_d  = mem_data_q;
    addr_d      = addr_q;
    imm_d       = imm_q;
    op_d        = op_q;
    imm_size_d  = imm_size_q;
    is_mem_wb_d = is_mem_wb_q;
    sr1_d       = sr1_q;
    far_jmp_d   = far_jmp_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          src1_d      = i_reg1[31:0];
          src2_d      = i_reg1[63:32];
          addr_d      = i_reg3;
          imm_d       = i_reg2[IMM_MSB:IMM_LSB];
          op_d        = i_reg2[OP_MSB:OP_LSB];
          imm_size_d  = i_reg2[IMMSZ_MSB:IMMSZ_LSB];
          is_mem_wb_d = i_reg2[ISMEMWB_BIT];
          sr1_d       = i_reg2[SR1_MSB:SR1_LSB];
          far_jmp_d   = i_reg2[FARJMP_BIT];
          word1_d     = 32'd0;
          word2_d     = 32'd0;
          if (i_reg2[ISMEMRD_BIT]) begin
            state_d   = ST_RD1;
            dc_req_d  = 1'b1;
            dc_addr_d = {i_reg3[31:2], 2'b00};
          end else begin
            valid_d    = 1'b1;
            mem_data_d = 32'd0;
          end
        end
      end

      ST_RD1: begin
        if (ack) begin
          word1_d = dc_rdata;
          if (is_split(addr_q[1:0], op_q)) begin
            state_d   = ST_RD2;
            dc_addr_d = dc_addr_q + WORD_STRIDE;
          end else begin
            state_d  = ST_DONE;
            dc_req_d = 1'b0;
          end
        end
      end

      ST_RD2: begin
        if (ack) begin
          word2_d  = dc_rdata;
          dc_req_d = 1'b0;
          state_d  = ST_DONE;
        end
      end

      ST_DONE: begin
        mem_data_d = aligned_data;
        valid_d    = 1'b1;
        state_d    = ST_IDLE;
      end

      default: begin
        state_d  = ST_IDLE;
        dc_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears everything and abandons any request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      dc_req_q    <= 1'b0;
      dc_addr_q   <= 32'd0;
      word1_q     <= 32'd0;
      word2_q     <= 32'd0;
      valid_q     <= 1'b0;
      src1_q      <= 32'd0;
      src2_q      <= 32'd0;
      mem_data_q  <= 32'd0;
      addr_q      <= 32'd0;
      imm_q       <= 48'd0;
      op_q        <= 2'd0;
      imm_size_q  <= 2'd0;
      is_mem_wb_q <= 1'b0;
      sr1_q       <= 3'd0;
      far_jmp_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      dc_req_q    <= dc_req_d;
      dc_addr_q   <= dc_addr_d;
      word1_q     <= word1_d;
      word2_q     <= word2_d;
      valid_q     <= valid_d;
      src1_q      <= src1_d;
      src2_q      <= src2_d;
      mem_data_q  <= mem_data_d;
      addr_q      <= addr_d;
      imm_q       <= imm_d;
      op_q        <= op_d;
      imm_size_q  <= imm_size_d;
      is_mem_wb_q <= is_mem_wb_d;
      sr1_q       <= sr1_d;
      far_jmp_q   <= far_jmp_d;
    end
  end

  assign dc_req     = dc_req_q;
  assign dc_addr    = dc_addr_q;
  assign o_valid    = valid_q;
  assign o_src1     = src1_q;
  assign o_src2     = src2_q;
  assign o_mem_data = mem_data_q;
  assign o_addr     = addr_q;
  assign o_imm      = imm_q;
  assign o_op       = op_q;
  assign o_immSize  = imm_size_q;
  assign o_isMemWb  = is_mem_wb_q;
  assign o_sr1      = sr1_q;
  assign o_far_jmp  = far_jmp_q;

endmodule

// File: doc/mem_read_stage.md
MEM_READ_STAGE -- requirements
Module: mem_read_stage

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk and rst.
REQ-002 The ports SHALL be:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- i_valid  in  1  AG2 pipeline registers hold a valid instruction.
- i_reg1  in  64  [31:0] sr1 value, [63:32] sr2 value.
- i_reg2  in  64  [47:0] imm, [49:48] op, [51:50] immSize, [52] isMemWb, [53] isMemRd, [56:54] sr1, [57] far_jmp, [63:58] zero.
- i_reg3  in  32  effective address.
- o_stall  out  1  upstream SHALL hold i_* while high.
- dc_req  out  1  data-cache read request.
- dc_addr  out  32  word-aligned read address, addr[1:0]=0.
- dc_ack  in  1  read data valid this cycle.
- dc_rdata  in  32  read data, little-endian.
- i_ex_ready  in  1  execute stage accepts the output this cycle.
- o_valid  out  1  output bundle valid.
- o_src1, o_src2, o_mem_data, o_addr  out  32 each  operands, loaded memory operand, address.
- o_imm 48, o_op 2, o_immSize 2, o_isMemWb 1, o_sr1 3, o_far_jmp 1  out  fields forwarded from i_reg2.

Function
REQ-003 An input SHALL be accepted on a rising edge when i_valid=1 and o_stall=0.
REQ-004 o_stall SHALL be 1 when FSM != IDLE, or when o_valid=1 and i_ex_ready=0.
REQ-005 The operand size SHALL be decoded from op: 00=1 byte, 01=2 bytes, 10 and 11=4 bytes.
REQ-006 The FSM SHALL have four states: IDLE, RD1, RD2, DONE.
REQ-007 If an accepted input has isMemRd=0, the FSM SHALL stay in IDLE, and o_valid SHALL rise the next cycle with o_mem_data=0.
REQ-008 If an accepted input has isMemRd=1, the FSM SHALL go to RD1 with dc_req=1 and dc_addr={addr[31:2],2'b00}.
REQ-009 The block SHALL define split as addr[1:0]+size>4.
REQ-010 On dc_ack in RD1, the block SHALL capture dc_rdata and go to RD2 if split, otherwise to DONE.
REQ-011 RD2 SHALL hold dc_addr=first address+4; address arithmetic SHALL be 32-bit and SHALL wrap from 0xFFFFFFFC to 0x00000000.
REQ-012 On dc_ack in RD2, the block SHALL capture the second word and go to DONE.
REQ-013 In DONE, the {word2,word1} value SHALL be shifted right by 8*addr[1:0] and zero-extended to the operand size into o_mem_data. The block SHALL then assert o_valid and return to IDLE.
REQ-014 dc_req and dc_addr SHALL stay stable until the dc_ack cycle. dc_req SHALL drop the cycle after dc_ack, with one request outstanding at most.
REQ-015 dc_ack SHALL be ignored when dc_req=0.
REQ-016 Minimum latency SHALL be: non-memory instruction 1 cycle; aligned read 3 cycles with dc_ack in the first request cycle; split read 4 cycles.
REQ-017 o_valid and all output fields SHALL hold while i_ex_ready=0. o_valid SHALL clear after a handshake unless a new bundle loads in the same edge.
REQ-018 Back-to-back non-memory inputs with i_ex_ready held high SHALL give one output per cycle.
REQ-019 All forwarded fields, o_src1/o_src2 and o_addr SHALL be registered at acceptance and SHALL be unchanged by the read.

Reset
REQ-020 rst SHALL set the FSM to IDLE and clear o_valid, dc_req, dc_addr, all data outputs and the capture registers.
REQ-021 rst SHALL take priority over every other event. A dc_ack received in the reset cycle or later for an aborted request SHALL be discarded.

Structure
REQ-022 A shared package SHALL hold: the i_reg2 bit positions, the size codes, the FSM state encoding, and the word stride constant 4.
REQ-023 The byte merge/shift/zero-extend SHALL be a combinational sub-module named mrd_align. The FSM and registers SHALL stay in mem_read_stage.

Verification
REQ-024 Non-memory op: i_reg2[53]=0, i_reg1=0x0000000200000001, i_ex_ready=1 -> next cycle o_valid=1, o_src1=1, o_src2=2, o_mem_data=0.
REQ-025 Aligned dword read: addr=0x1000, op=10, dc_ack one cycle after dc_req, dc_rdata=0xDEADBEEF -> dc_addr=0x1000 and o_mem_data=0xDEADBEEF.
REQ-026 Split word read: addr=0x1003, op=01, with reads returning 0x11223344 at 0x1000 and 0x55667788 at 0x1004 -> two requests (0x1000, 0x1004) and o_mem_data=0x00008811.
REQ-027 Wrap: addr=0xFFFFFFFE, op=10 -> second dc_addr=0x00000000.
REQ-028 Backpressure: i_ex_ready=0 for 3 cycles with o_valid=1 -> outputs stable, o_stall=1, no new input accepted.
REQ-029 Reset mid-read: rst in RD1, dc_ack arrives 2 cycles later -> dc_req=0, o_valid stays 0, FSM in IDLE.
